// File: rtl/spec_op_ctrl_pkg.sv
// spec_op_ctrl_pkg: shared instruction-class and spec-op controller state definitions.
package spec_op_ctrl_pkg;
  typedef enum logic [2:0] {
    OP_ALU,
    OP_CSR,
    OP_TLB,
    OP_CACHE,
    OP_IDLE
  } optype_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ISSUE,
    S_WAIT,
    S_FLUSH,
    S_SLEEP
  } spec_state_t;
  localparam logic [31:0] PC_STEP = 32'd4;
  function automatic logic [31:0] refetch_of(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction
endpackage

// File: rtl/spec_op_watchdog.sv
// spec_op_watchdog: WAIT-state cycle counter; built only with SPEC_OP_TIMEOUT_EN defined.
`ifdef SPEC_OP_TIMEOUT_EN
module spec_op_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d = clear_i ? '0 : enable_i ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  // Count starts at 0 in the first WAIT cycle, so expiry lands in WAIT cycle TIMEOUT_CYCLES.
  assign expire_o = enable_i & (cnt_q == 16'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/spec_op_ctrl.sv
// spec_op_ctrl: serialises special ops (CSR/TLB/cache/IDLE) and requests a refetch afterwards.
// Optional WAIT watchdog with timeout_o when SPEC_OP_TIMEOUT_EN is defined.
module spec_op_ctrl
  import spec_op_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        id_valid,
  input  logic        id_is_spec,
  input  logic        id_is_idle,
  input  logic        id_excp,
  input  logic [31:0] id_pc,
  input  logic        pipe_empty,
  input  logic        op_done,
  input  logic        intr,
  input  logic        excp_flush,
  output logic        id_ready,
  output logic        issue_fire,
  output logic        flush_req,
  output logic [31:0] refetch_pc,
  output logic        busy
`ifdef SPEC_OP_TIMEOUT_EN
  ,
  output logic        timeout_o
`endif
);
  spec_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        idle_q, idle_d;
  logic        spec_hit, done;
  assign spec_hit = id_valid & id_is_spec & ~id_excp;
`ifdef SPEC_OP_TIMEOUT_EN
  logic wd_expire;
  spec_op_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear_i (state_q != S_WAIT),
    .enable_i(state_q == S_WAIT),
    .expire_o(wd_expire)
  );
  assign done      = op_done | wd_expire;
  assign timeout_o = wd_expire & ~excp_flush;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign done = op_done;
`endif
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    idle_d     = idle_q;
    id_ready   = 1'b0;
    issue_fire = 1'b0;
    flush_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        id_ready = ~spec_hit;
        if (spec_hit) begin
          state_d = S_DRAIN;
          pc_d    = id_pc;
          idle_d  = id_is_idle;
        end
      end
      S_DRAIN: state_d = pipe_empty ? S_ISSUE : S_DRAIN;
      S_ISSUE: begin
        id_ready   = 1'b1;
        issue_fire = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT:  state_d = done ? (idle_q ? S_SLEEP : S_FLUSH) : S_WAIT;
      S_SLEEP: state_d = intr ? S_FLUSH : S_SLEEP;
      S_FLUSH: begin
        flush_req = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A commit-stage flush overrides everything, including a same-cycle completion.
    if (excp_flush) begin
      state_d    = S_IDLE;
      issue_fire = 1'b0;
      flush_req  = 1'b0;
    end
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idle_q  <= idle_d;
    end
  end
  assign refetch_pc = refetch_of(pc_q);
  assign busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_spec_op_ctrl.sv
// tb_spec_op_ctrl: directed self-checking bench for spec_op_ctrl.
module tb_spec_op_ctrl;
  logic        aclk = 1'b0;
  logic        aresetn, id_valid, id_is_spec, id_is_idle, id_excp;
  logic [31:0] id_pc;
  logic        pipe_empty, op_done, intr, excp_flush;
  logic        id_ready, issue_fire, flush_req, busy;
  logic [31:0] refetch_pc;
  int          checks = 0, failures = 0, fire_cnt = 0, flush_cnt = 0, snap;
`ifdef SPEC_OP_TIMEOUT_EN
  logic        timeout_o;
`endif

  spec_op_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .id_valid  (id_valid),
    .id_is_spec(id_is_spec),
    .id_is_idle(id_is_idle),
    .id_excp   (id_excp),
    .id_pc     (id_pc),
    .pipe_empty(pipe_empty),
    .op_done   (op_done),
    .intr      (intr),
    .excp_flush(excp_flush),
    .id_ready  (id_ready),
    .issue_fire(issue_fire),
    .flush_req (flush_req),
    .refetch_pc(refetch_pc),
    .busy      (busy)
`ifdef SPEC_OP_TIMEOUT_EN
    ,
    .timeout_o (timeout_o)
`endif
  );

  always #5 aclk = ~aclk;
  always @(negedge aclk) begin
    if (issue_fire) fire_cnt++;
    if (flush_req) flush_cnt++;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic rdy, input logic fire, input logic fl, input logic bsy);
    chk({tag, ".id_ready"}, 32'(id_ready), 32'(rdy));
    chk({tag, ".issue_fire"}, 32'(issue_fire), 32'(fire));
    chk({tag, ".flush_req"}, 32'(flush_req), 32'(fl));
    chk({tag, ".busy"}, 32'(busy), 32'(bsy));
  endtask

  task automatic spec(input logic [31:0] pc, input logic idle);
    id_valid = 1'b1; id_is_spec = 1'b1; id_is_idle = idle; id_excp = 1'b0; id_pc = pc;
  endtask

  task automatic no_id();
    id_valid = 1'b0; id_is_spec = 1'b0; id_is_idle = 1'b0; id_excp = 1'b0; id_pc = 32'h0;
  endtask

  initial begin
    aresetn = 1'b0; pipe_empty = 1'b0; op_done = 1'b0; intr = 1'b0; excp_flush = 1'b0;
    no_id();
    #1;
    outs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset.refetch_pc", refetch_pc, 32'h4);
`ifdef SPEC_OP_TIMEOUT_EN
    chk("reset.timeout_o", 32'(timeout_o), 32'h0);
`endif
    spec(32'h1C000100, 1'b0);
    #1;
    chk("reset.spec_hit_ready", 32'(id_ready), 32'h0);
    no_id();
    tick(); tick();
    aresetn = 1'b1;
    // CSR op: pipe drains after 3 cycles, op_done 2 cycles after issue
    spec(32'h1C000100, 1'b0);
    #1;
    outs("csr.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    outs("csr.drain1", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    pipe_empty = 1'b1;
    #1;
    outs("csr.drain3", 1'b0, 1'b0, 1'b0, 1'b1);
    snap = fire_cnt;
    tick();
    no_id();
    outs("csr.issue", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    outs("csr.wait1", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    op_done = 1'b1;
    #1;
    outs("csr.wait2", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    op_done = 1'b0;
    outs("csr.flush", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("csr.refetch_pc", refetch_pc, 32'h1C000104);
    tick();
    outs("csr.done", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("csr.fire_count", 32'(fire_cnt - snap), 32'd1);
    // IDLE op with same-cycle pipe_empty: still one drain cycle, then sleep until intr
    spec(32'h1C000200, 1'b1);
    tick();
    outs("idle.drain", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    no_id();
    outs("idle.issue", 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    for (int i = 0; i < 9; i++) begin
      op_done = (i == 3);
      #1;
      outs("idle.sleep", 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    op_done = 1'b0;
    intr = 1'b1;
    #1;
    outs("idle.intr", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    intr = 1'b0;
    outs("idle.flush", 1'b0, 1'b0, 1'b1, 1'b1);
    chk("idle.refetch_pc", refetch_pc, 32'h1C000204);
    tick();
    outs("idle.done", 1'b1, 1'b0, 1'b0, 1'b0);
    // excp_flush beats op_done in WAIT
    spec(32'h1C000300, 1'b0);
    tick();
    no_id();
    tick();
    tick();
    op_done = 1'b1; excp_flush = 1'b1;
    #1;
    outs("excp.wait", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    op_done = 1'b0; excp_flush = 1'b0;
    outs("excp.after_wait", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("excp.no_flush", 32'(flush_req), 32'h0);
    // excp_flush in DRAIN cancels the issue
    snap = fire_cnt;
    spec(32'h1C000400, 1'b0);
    tick();
    no_id();
    excp_flush = 1'b1;
    #1;
    outs("excp.drain", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    excp_flush = 1'b0;
    outs("excp.after_drain", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("excp.no_issue", 32'(fire_cnt - snap), 32'd0);
    // excepting spec op and plain ALU op pass through
    spec(32'h1C000500, 1'b0);
    id_excp = 1'b1;
    #1;
    chk("pass.excp_ready", 32'(id_ready), 32'h1);
    tick();
    chk("pass.excp_busy", 32'(busy), 32'h0);
    id_excp = 1'b0; id_is_spec = 1'b0;
    #1;
    chk("pass.alu_ready", 32'(id_ready), 32'h1);
    tick();
    chk("pass.alu_busy", 32'(busy), 32'h0);
    // PC wrap, then asynchronous reset in WAIT
    spec(32'hFFFFFFFC, 1'b0);
    tick();
    no_id();
    chk("wrap.refetch_pc", refetch_pc, 32'h0);
    tick();
    tick();
    outs("wrap.wait", 1'b0, 1'b0, 1'b0, 1'b1);
    snap = flush_cnt;
    op_done = 1'b1;
    aresetn = 1'b0;
    #1;
    outs("rst.mid", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.refetch_pc", refetch_pc, 32'h4);
    tick();
    aresetn = 1'b1;
    tick();
    op_done = 1'b0;
    tick();
    outs("rst.after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst.no_flush", 32'(flush_cnt - snap), 32'd0);
`ifdef SPEC_OP_TIMEOUT_EN
    // watchdog: no op_done, timeout in 8th WAIT cycle, flush next cycle
    spec(32'h1C000600, 1'b0);
    tick();
    no_id();
    tick();
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("wd.timeout_o", 32'(timeout_o), 32'(i == 8));
      chk("wd.flush_req", 32'(flush_req), 32'h0);
      tick();
    end
    chk("wd.flush", 32'(flush_req), 32'h1);
    chk("wd.refetch_pc", refetch_pc, 32'h1C000604);
    chk("wd.timeout_clear", 32'(timeout_o), 32'h0);
    tick();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spec_op_ctrl.md
SPEC_OP_CTRL -- requirements
Module: spec_op_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning WAIT-state watchdog limit in cycles (range 2..65535).
REQ-002 SHALL have port aclk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports id_valid / id_is_spec / id_is_idle / id_excp  in  1 each  ID-stage instruction valid, is_spec_op, is_idle, have_excp.
REQ-005 SHALL have port id_pc  in  32  PC of ID-stage instruction.
REQ-006 SHALL have port pipe_empty  in  1  no older instruction in flight past ID.
REQ-007 SHALL have port op_done  in  1  completion pulse from CSR/TLB/cache unit.
REQ-008 SHALL have port intr  in  1  pending interrupt (wakes IDLE).
REQ-009 SHALL have port excp_flush  in  1  commit-stage exception/ERTN flush.
REQ-010 SHALL have port id_ready  out  1  ID may hand its instruction to EX1 this cycle.
REQ-011 SHALL have port issue_fire  out  1  spec op enters EX1 this cycle.
REQ-012 SHALL have ports flush_req  out  1  and refetch_pc  out  32  refetch redirect.
REQ-013 SHALL have port busy  out  1  state != S_IDLE.

Function
REQ-014 SHALL implement states S_IDLE, S_DRAIN, S_ISSUE, S_WAIT, S_FLUSH, S_SLEEP.
REQ-015 "spec_hit" = id_valid & id_is_spec & !id_excp; spec ops carrying exceptions pass through untouched.
REQ-016 S_IDLE: id_ready = !spec_hit (combinational); spec_hit -> S_DRAIN, capture pc_q=id_pc, idle_q=id_is_idle.
REQ-017 S_DRAIN: id_ready=0; pipe_empty -> S_ISSUE; same-cycle spec_hit and pipe_empty in S_IDLE still pass through S_DRAIN (min 1 drain cycle).
REQ-018 S_ISSUE: id_ready=1, issue_fire=1 for exactly one cycle -> S_WAIT.
REQ-019 S_WAIT: id_ready=0; op_done -> S_SLEEP if idle_q else S_FLUSH.
REQ-020 S_SLEEP: id_ready=0; intr -> S_FLUSH.
REQ-021 S_FLUSH: flush_req=1 one cycle, refetch_pc = pc_q + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000) -> S_IDLE.
REQ-022 refetch_pc SHALL be pc_q + 4 in all states; consumers qualify with flush_req.
REQ-023 excp_flush in any state SHALL force S_IDLE next cycle, suppress flush_req and issue_fire that cycle; beats simultaneous op_done/intr.
REQ-024 issue-to-flush latency SHALL be: op_done in cycle N -> flush_req in cycle N+1.
REQ-025 op_done outside S_WAIT and intr outside S_SLEEP SHALL be ignored.

Reset
REQ-026 aresetn low SHALL force S_IDLE, pc_q=0, idle_q=0, watchdog=0 immediately; outputs: id_ready=!spec_hit, issue_fire=0, flush_req=0, busy=0, refetch_pc=4.
REQ-027 Reset mid-operation SHALL abandon the op silently; no flush_req on release.

Configuration
REQ-028 Macro SPEC_OP_TIMEOUT_EN defined: counter increments each S_WAIT cycle, cleared on entry; reaching TIMEOUT_CYCLES without op_done SHALL act as op_done (-> S_FLUSH/S_SLEEP) and pulse output timeout_o for one cycle.
REQ-029 Macro undefined: no counter, no timeout_o port, S_WAIT exits only on op_done/excp_flush.

Structure
REQ-030 spec_state_t enum SHALL live in the shared definitions package beside optype_t.
REQ-031 Watchdog SHALL be sub-module spec_op_watchdog (clear, enable, expire), instantiated only under SPEC_OP_TIMEOUT_EN; no other sub-modules.

Verification
REQ-032 CSR op at pc 0x1C000100, pipe_empty after 3 cycles, op_done 2 cycles after issue_fire -> one issue_fire, flush_req with refetch_pc=0x1C000104, busy cleared next cycle.
REQ-033 IDLE at pc 0x1C000200, op_done then intr 10 cycles later -> stays S_SLEEP, id_ready=0, flush_req one cycle after intr, refetch_pc=0x1C000204.
REQ-034 excp_flush same cycle as op_done in S_WAIT -> S_IDLE, no flush_req; excp_flush in S_DRAIN -> no issue_fire.
REQ-035 Spec op with id_excp=1 and plain ALU ops -> id_ready=1, controller stays S_IDLE, busy=0.
REQ-036 pc_q=0xFFFFFFFC -> refetch_pc=0x00000000; aresetn low during S_WAIT -> all outputs at reset values, no flush_req after release.
REQ-037 SPEC_OP_TIMEOUT_EN, TIMEOUT_CYCLES=8, no op_done -> timeout_o and S_FLUSH after 8 WAIT cycles, flush_req next cycle.
